// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Write side of instruction memory. Takes a byte stream (typically the UART
// receive path, driven by the BIOS), parses a little-endian header made of a
// 32-bit base address and a 32-bit payload length, and packs the payload
// into 32-bit words. Each completed word becomes one registered IMEM write
// with per-byte enables. A one-cycle done pulse, qualified by error, closes
// every transfer.
//
// Parameters
//   IMEM_AWIDTH  IMEM word-address width (default 14 -> 16K words, 64 KB)
//   IMEM_REGION  required value of base[31:28]
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      one-cycle pulse that arms the loader (ignored unless idle)
//   in_data_i    stream byte
//   in_valid_i   stream byte is valid
//   in_ready_o   loader accepts a byte this cycle
//   imem_addr_o  IMEM word address
//   imem_din_o   IMEM write data
//   imem_we_o    per-byte write enables (bit k covers din[8k+7:8k])
//   busy_o       loader is outside IDLE
//   done_o       one-cycle completion pulse
//   error_o      qualified by done_o; 1 = transfer rejected, nothing written
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int          IMEM_AWIDTH = 14,
  parameter logic [3:0]  IMEM_REGION = 4'h1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [7:0]             in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [IMEM_AWIDTH-1:0] imem_addr_o,
  output logic [31:0]            imem_din_o,
  output logic [3:0]             imem_we_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_FIN
  } state_t;

  state_t                 state_q;
  logic [1:0]             idx_q;
  logic [31:0]            base_q;
  logic [31:0]            rem_q;
  logic [IMEM_AWIDTH-1:0] waddr_q;
  logic [31:0]            word_q;
  logic                   bad_q;

  logic                   in_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic [IMEM_AWIDTH-1:0] imem_addr_q;
  logic [31:0]            imem_din_q;
  logic [3:0]             imem_we_q;

  logic                   accept;
  logic [31:0]            len_full;
  logic                   bad_now;
  logic [31:0]            word_merged;
  logic [3:0]             lane_mask;
  logic [31:0]            rem_dec;
  logic                   word_last;

  // Only some base bits select the word address and region; the rest of the
  // header field is legitimately ignored.
  logic                   unused_base;
  assign unused_base = ^base_q;

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_din_o  = imem_din_q;
  assign imem_we_o   = imem_we_q;

  // Handshake decode plus the datapath values needed on the accepting edge.
  // The length is shifted into rem_q LSB-first, so on the 4th LEN byte the
  // complete length is the incoming byte on top of the upper three already
  // held. The base is fully captured by the time LEN starts, so the region
  // and alignment check can be evaluated straight from base_q.
  always_comb begin
    accept      = in_valid_i && in_ready_q;
    len_full    = {in_data_i, rem_q[31:8]};
    bad_now     = (base_q[1:0] != 2'b00) || (base_q[31:28] != IMEM_REGION);
    rem_dec     = rem_q - 32'd1;
    word_last   = (idx_q == 2'd3) || (rem_q == 32'd1);
    word_merged = word_q;
    word_merged[{idx_q, 3'b000} +: 8] = in_data_i;
    lane_mask   = 4'h0;
    case (idx_q)
      2'd0:    lane_mask = 4'h1;
      2'd1:    lane_mask = 4'h3;
      2'd2:    lane_mask = 4'h7;
      default: lane_mask = 4'hF;
    endcase
  end

  // Single-process FSM with registered outputs. Write strobes, done and
  // error default low every cycle so each is a one-cycle pulse; reset wins
  // over everything, which also cancels a write that would otherwise be
  // registered on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      base_q      <= 32'd0;
      rem_q       <= 32'd0;
      waddr_q     <= '0;
      word_q      <= 32'd0;
      bad_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      imem_addr_q <= '0;
      imem_din_q  <= 32'd0;
      imem_we_q   <= 4'h0;
    end else begin
      imem_we_q <= 4'h0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_ADDR;
            idx_q      <= 2'd0;
            rem_q      <= 32'd0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end

        S_ADDR: begin
          if (accept) begin
            base_q <= {in_data_i, base_q[31:8]};
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= S_LEN;
            end
          end
        end

        S_LEN: begin
          if (accept) begin
            rem_q <= len_full;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              bad_q   <= bad_now;
              waddr_q <= base_q[IMEM_AWIDTH+1:2];
              word_q  <= 32'd0;
              if (len_full == 32'd0) begin
                state_q    <= S_FIN;
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
                error_q    <= bad_now;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end

        // A word closes on lane 3 or on the final payload byte; a rejected
        // transfer still consumes every byte but never strobes IMEM.
        S_DATA: begin
          if (accept) begin
            rem_q <= rem_dec;
            if (word_last) begin
              if (!bad_q) begin
                imem_we_q   <= lane_mask;
                imem_addr_q <= waddr_q;
                imem_din_q  <= word_merged;
              end
              waddr_q <= waddr_q + 1'b1;
              idx_q   <= 2'd0;
              word_q  <= 32'd0;
            end else begin
              word_q <= word_merged;
              idx_q  <= idx_q + 2'd1;
            end
            if (rem_dec == 32'd0) begin
              state_q    <= S_FIN;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
              error_q    <= bad_q;
            end
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Each load computes the IMEM writes it
// should cause from its own base/length/payload and queues them as the bytes
// are driven; a negedge monitor pops and compares every write the loader
// issues. Per-scenario tasks also check write latency, done/error timing and
// the control outputs inline.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_din;
  logic [3:0]    imem_we;
  logic          busy;
  logic          done;
  logic          error;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    we;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] pay[$];
  int         passCount   = 0;
  int         checkCount  = 0;
  int         consecCount = 0;
  logic [3:0] prevWe      = 4'h0;
  wr_t        monExp;

  imem_loader #(
    .IMEM_AWIDTH(AW),
    .IMEM_REGION(4'h1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .imem_addr_o (imem_addr),
    .imem_din_o  (imem_din),
    .imem_we_o   (imem_we),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write strobe must match the oldest expected
  // write; back-to-back strobes are tallied for the gapped-stream check.
  always @(negedge clk) begin
    if (imem_we !== 4'h0) begin
      if (prevWe !== 4'h0) consecCount++;
      checkCount++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL write_unexpected: got addr=%0d din=%h we=%h, wanted no write",
                 imem_addr, imem_din, imem_we);
      end else begin
        monExp = sb.pop_front();
        if (imem_addr !== monExp.addr || imem_din !== monExp.din || imem_we !== monExp.we)
          $display("[TB] FAIL write_data: got addr=%0d din=%h we=%h, wanted addr=%0d din=%h we=%h",
                   imem_addr, imem_din, imem_we, monExp.addr, monExp.din, monExp.we);
        else
          passCount++;
      end
    end
    prevWe = imem_we;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation still running, wanted completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_bytes(input logic [63:0] bytes, input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(bytes[8*i +: 8]);
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit gapped, input bit pulseStart);
    if (gapped) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = pulseStart;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Drives one full transfer of pay[] and checks it cycle by cycle.
  task automatic load(input string name, input logic [31:0] base, input logic [31:0] len,
                      input bit gapped, input bit startMid);
    bit            bad;
    bit            last;
    logic [AW-1:0] waddr;
    logic [31:0]   word;
    logic [3:0]    mask;
    logic [3:0]    expWe;
    logic [7:0]    b;
    int            lane;
    wr_t           e;

    bad   = (base[1:0] != 2'b00) || (base[31:28] != 4'h1);
    waddr = base[AW+1:2];
    word  = 32'd0;

    start = 1'b1;
    tick();
    start = 1'b0;
    checkCount++;
    if (busy !== 1'b1 || in_ready !== 1'b1)
      $display("[TB] FAIL %s_armed: got busy=%b ready=%b, wanted 1/1", name, busy, in_ready);
    else passCount++;

    for (int i = 0; i < 8; i++) begin
      b = (i < 4) ? base[8*i +: 8] : len[8*(i-4) +: 8];
      drive_byte(b, gapped, 1'b0);
      checkCount++;
      if (i == 7 && len == 32'd0) begin
        if (done !== 1'b1 || error !== bad)
          $display("[TB] FAIL %s_done: got done=%b error=%b, wanted 1/%b", name, done, error, bad);
        else passCount++;
      end else begin
        if (done !== 1'b0)
          $display("[TB] FAIL %s_hdr_done: got done=%b after header byte %0d, wanted 0", name, done, i);
        else passCount++;
      end
    end

    for (int i = 0; i < int'(len); i++) begin
      lane = i % 4;
      word[8*lane +: 8] = pay[i];
      last  = (lane == 3) || (i == int'(len) - 1);
      mask  = 4'hF >> (3 - lane);
      expWe = (last && !bad) ? mask : 4'h0;
      if (last && !bad) begin
        e.addr = waddr;
        e.din  = word;
        e.we   = mask;
        sb.push_back(e);
      end
      drive_byte(pay[i], gapped, startMid && (i == 1));
      checkCount++;
      if (imem_we !== expWe)
        $display("[TB] FAIL %s_we_latency: got we=%h after byte %0d, wanted %h", name, imem_we, i, expWe);
      else passCount++;
      checkCount++;
      if (i == int'(len) - 1) begin
        if (done !== 1'b1 || error !== bad)
          $display("[TB] FAIL %s_done: got done=%b error=%b, wanted 1/%b", name, done, error, bad);
        else passCount++;
      end else begin
        if (done !== 1'b0)
          $display("[TB] FAIL %s_early_done: got done=%b after byte %0d, wanted 0", name, done, i);
        else passCount++;
      end
      if (last) begin
        waddr = waddr + 1'b1;
        word  = 32'd0;
      end
    end

    tick();
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL %s_idle: got busy=%b done=%b ready=%b, wanted 0/0/0", name, busy, done, in_ready);
    else passCount++;
    checkCount++;
    if (sb.size() !== 0)
      $display("[TB] FAIL %s_drain: got %0d writes outstanding, wanted 0", name, sb.size());
    else passCount++;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    checkCount++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0)
      $display("[TB] FAIL reset_ctrl: got ready=%b busy=%b done=%b error=%b, wanted 0000",
               in_ready, busy, done, error);
    else passCount++;
    checkCount++;
    if (imem_we !== 4'h0 || imem_addr !== '0 || imem_din !== 32'd0)
      $display("[TB] FAIL reset_imem: got we=%h addr=%0d din=%h, wanted 0/0/0", imem_we, imem_addr, imem_din);
    else passCount++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    add_bytes(64'h0000_12B7_0000_0013, 8);
    load("nominal", 32'h1000_0000, 32'd8, 1'b0, 1'b0);
  endtask

  task automatic test_partial();
    add_bytes(64'h0000_FFEE_DDCC_BBAA, 6);
    load("partial", 32'h1000_0010, 32'd6, 1'b0, 1'b0);
  endtask

  task automatic test_gapped();
    add_bytes(64'h0000_12B7_0000_0013, 8);
    load("gapped_nominal", 32'h1000_0000, 32'd8, 1'b1, 1'b0);
    add_bytes(64'h0000_FFEE_DDCC_BBAA, 6);
    load("gapped_partial", 32'h1000_0010, 32'd6, 1'b1, 1'b0);
    checkCount++;
    if (consecCount !== 0)
      $display("[TB] FAIL gapped_consecutive_we: got %0d back-to-back strobes, wanted 0", consecCount);
    else passCount++;
  endtask

  task automatic test_errors();
    add_bytes(64'h0000_0000_4433_2211, 4);
    load("err_align", 32'h1000_0002, 32'd4, 1'b0, 1'b0);
    load("err_region", 32'h2000_0000, 32'd4, 1'b0, 1'b0);
  endtask

  task automatic test_len0();
    pay.delete();
    load("len0", 32'h1000_0100, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    add_bytes(64'h0807_0605_0403_0201, 8);
    load("wrap", 32'h1000_FFFC, 32'd8, 1'b0, 1'b0);
  endtask

  task automatic test_start_mid();
    add_bytes(64'h0000_12B7_0000_0013, 8);
    load("start_mid", 32'h1000_0000, 32'd8, 1'b0, 1'b1);
  endtask

  task automatic test_rst_mid();
    logic [31:0] base;
    logic [31:0] len;
    base = 32'h1000_0000;
    len  = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) drive_byte(base[8*i +: 8], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_byte(len[8*i +: 8], 1'b0, 1'b0);
    drive_byte(8'hA1, 1'b0, 1'b0);
    drive_byte(8'hA2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkCount++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || imem_we !== 4'h0)
      $display("[TB] FAIL rst_mid: got busy=%b ready=%b done=%b we=%h, wanted 0/0/0/0",
               busy, in_ready, done, imem_we);
    else passCount++;
    // Stray stream bytes while idle must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (in_ready !== 1'b0 || busy !== 1'b0)
        $display("[TB] FAIL idle_ignore: got ready=%b busy=%b, wanted 0/0", in_ready, busy);
      else passCount++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reload();
    add_bytes(64'h0000_0000_CAFE_F00D, 4);
    load("reload", 32'h1000_0040, 32'd4, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_partial();
    test_gapped();
    test_errors();
    test_len0();
    test_wrap();
    test_start_mid();
    test_rst_mid();
    test_reload();
    repeat (3) tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writes program images into IMEM from a byte stream, such as the UART receive path under BIOS control. It is the write side of instruction memory; the fetch stage reads from the other port. The loader takes a header and a little-endian payload, then packs the payload into 32-bit words. It issues one registered IMEM write per word, with byte enables, and reports completion or error.

## Interface
Parameters:
- IMEM_AWIDTH, default 14: IMEM word-address width (16K words, 64 KB).
- IMEM_REGION, default 4'h1: required value of base address bits [31:28].

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  one-cycle pulse that arms the loader; ignored unless idle.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_addr  output  IMEM_AWIDTH  IMEM word address.
- imem_din  output  32  IMEM write data.
- imem_we  output  4  per-byte write enables (bit k covers din[8k+7:8k]).
- busy  output  1  loader is outside IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  valid only with done; 1 means the transfer was rejected and nothing was written.

## Operation
- A transfer is accepted when in_valid and in_ready are both high.
- States: IDLE, ADDR, LEN, DATA, FIN.
- IDLE: in_ready=0. On start, go to ADDR and clear the byte index.
- ADDR: accept 4 bytes, least significant first, into base[31:0].
- LEN: accept 4 bytes, least significant first, into len[31:0] (payload length in bytes). Base is checked after the 4th byte:
  - bad = (base[1:0]!=0) or (base[31:28]!=IMEM_REGION).
  - If len==0, go to FIN.
  - Otherwise go to DATA with remaining=len and waddr=base[IMEM_AWIDTH+1:2].
- DATA: accept one byte per handshake into lane idx (0..3), then decrement remaining.
  - A word completes when idx==3 or remaining reaches 0.
  - On word completion, if not bad: register a write with imem_addr=waddr, imem_din=the assembled word (unreceived lanes 0), and imem_we=the mask of received lanes (4'hF for a full word; 4'h1, 4'h3 or 4'h7 for a short final word).
  - Then waddr increments modulo 2^IMEM_AWIDTH (wraps from 16383 to 0) and idx clears.
  - If bad, payload bytes are consumed and dropped and no write is issued.
  - When remaining reaches 0, go to FIN.
- FIN: done=1 and error=bad for one cycle, then go to IDLE.
- in_ready=1 in ADDR, LEN and DATA. The loader never applies backpressure mid-transfer.
- start while busy is ignored.
- in_valid in IDLE is ignored; no byte is consumed.
- The remaining counter is 32-bit. A length that is not a multiple of 4 yields one partial final word.

## Timing
- Reset values: in_ready=0, busy=0, done=0, error=0, imem_we=0, imem_addr=0, imem_din=0. State=IDLE and all counters are cleared.
- rst mid-transfer drops to IDLE at the next edge. No partial word is written, and the pending write pulse is cancelled if rst is high in that cycle.
- Write latency: imem_we is high for exactly one cycle, the cycle after the handshake that completes the word. imem_addr and imem_din are valid in that same cycle. imem_we is 0 in every other cycle.
- Back-to-back bytes every cycle give one write per 4 cycles, with no gaps.
- The FIN cycle, with done=1, is the cycle after the last payload handshake, and coincides with the final imem_we pulse.
- len==0: FIN (done) is the cycle after the 4th LEN byte.
- busy rises the cycle after start and falls the cycle after done.
- Throughput is limited only by in_valid. Minimum transfer time is 8 + len cycles plus 1 for FIN.

## Test plan
- Nominal load: start; base=0x1000_0000; len=8; payload 0x13,0x00,0x00,0x00,0xB7,0x12,0x00,0x00.
  - Expect writes (addr 0, din 0x0000_0013, we 4'hF), then (addr 1, din 0x0000_12B7, we 4'hF).
  - Expect done=1, error=0 coincident with the second write.
- Partial tail: base=0x1000_0010, len=6, payload AA BB CC DD EE FF.
  - Expect (addr 4, 0xDDCCBBAA, 4'hF), then (addr 5, 0x0000FFEE, 4'h3).
- Gapped stream: the same image with in_valid toggling randomly.
  - Expect identical writes, one per completed word, with imem_we never high for two consecutive cycles.
- Errors, each with len=4:
  - base=0x1000_0002 gives 4 bytes consumed, no imem_we, then done=1 with error=1.
  - base=0x2000_0000 gives the same result.
- Edges:
  - len=0 gives done the cycle after the last LEN byte, with no writes.
  - base=0x1000_FFFC, len=8 gives writes to addr 16383, then addr 0.
- Control:
  - start pulsed mid-DATA has no effect.
  - rst asserted after 2 of 4 payload bytes gives no write, with busy, in_ready and done at 0 the next cycle.
  - A fresh load after that reset succeeds.
